// File: rtl/div_arb_pkg.sv
// Shared types and width constants for the divider arbiter slice.
package div_arb_pkg;

   localparam int unsigned W_W = 10;  // dividend width
   localparam int unsigned D_W = 5;   // divisor width
   localparam int unsigned Q_W = 5;   // quotient width
   localparam int unsigned R_W = 6;   // remainder width

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/div_arbiter_if.sv
// Requester and divider-side signal bundle for div_arbiter.
// slave = arbiter view, master = requesters/divider view.
interface div_arbiter_if
   import div_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4
) ();

   localparam int unsigned ID_W = $clog2(N_REQ);

   // requester side
   logic [N_REQ-1:0]     req;
   logic [W_W*N_REQ-1:0] req_w;
   logic [D_W*N_REQ-1:0] req_d;
   logic [N_REQ-1:0]     ack;
   logic                 resp_valid;
   logic [ID_W-1:0]      resp_id;
   logic [Q_W-1:0]       resp_quo;
   logic [R_W-1:0]       resp_rem;
   logic                 resp_ov;
   logic                 resp_dbz;
   logic                 resp_to;
   logic                 busy;

   // divider side
   logic [W_W-1:0]       div_w;
   logic [D_W-1:0]       div_d;
   logic                 div_start;
   logic [Q_W-1:0]       div_quo;
   logic [R_W-1:0]       div_rem;
   logic                 div_done;
   logic                 div_ov;
   logic                 div_dbz;

   modport slave (
      input  req, req_w, req_d,
      input  div_quo, div_rem, div_done, div_ov, div_dbz,
      output ack, resp_valid, resp_id, resp_quo, resp_rem,
      output resp_ov, resp_dbz, resp_to, busy,
      output div_w, div_d, div_start
   );

   modport master (
      output req, req_w, req_d,
      output div_quo, div_rem, div_done, div_ov, div_dbz,
      input  ack, resp_valid, resp_id, resp_quo, resp_rem,
      input  resp_ov, resp_dbz, resp_to, busy,
      input  div_w, div_d, div_start
   );

endinterface

// File: rtl/div_rr_pick.sv
// Combinational round-robin picker: first set req bit found searching
// upward from last_served+1, wrapping modulo N_REQ (power of two).
module div_rr_pick #(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_served,
   output logic             gnt_valid,
   output logic [ID_W-1:0]  gnt_id
);

   logic [ID_W-1:0] idx;

   // Walk the N_REQ candidates in priority order, keep the first hit.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = '0;
      idx       = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = ID_W'(32'(last_served) + k);
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_id    = idx;
         end
      end
   end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one divider among N_REQ requesters.
// IDLE grants and latches operands, ISSUE pulses div_start, WAIT holds
// operands until div_done, RESP returns the registered result with ack.
// Optional feature macro: DIV_TIMEOUT_EN (WAIT watchdog, drives resp_to).
module div_arbiter
   import div_arb_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned TIMEOUT_CYC = 63
) (
   input logic         clk,
   input logic         rst,
   div_arbiter_if.slave bus
);

   localparam int unsigned ID_W = $clog2(N_REQ);

   state_t          state, state_nx;
   logic [ID_W-1:0] last_served;
   logic [ID_W-1:0] id_q;
   logic [W_W-1:0]  w_q;
   logic [D_W-1:0]  d_q;
   logic [Q_W-1:0]  quo_q;
   logic [R_W-1:0]  rem_q;
   logic            ov_q;
   logic            dbz_q;
   logic            gnt_valid;
   logic [ID_W-1:0] gnt_id;
   logic            to_exp;

   div_rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req         (bus.req),
      .last_served (last_served),
      .gnt_valid   (gnt_valid),
      .gnt_id      (gnt_id)
   );

`ifdef DIV_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 2);

   logic [TO_W-1:0] to_cnt;
   logic            to_q;

   // Watchdog counts WAIT cycles; held at zero elsewhere so WAIT entry starts at 0.
   always_ff @(posedge clk) begin
      if (rst || state != S_WAIT) to_cnt <= '0;
      else                        to_cnt <= to_cnt + 1'b1;
   end

   assign to_exp = (to_cnt == TO_W'(TIMEOUT_CYC));
`else
   assign to_exp = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; div_done only matters in WAIT.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (gnt_valid) state_nx = S_ISSUE;
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT:  if (bus.div_done || to_exp) state_nx = S_RESP;
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Grant latch, result capture and round-robin pointer update.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_served <= ID_W'(N_REQ - 1);
         id_q        <= '0;
         w_q         <= '0;
         d_q         <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         ov_q        <= 1'b0;
         dbz_q       <= 1'b0;
`ifdef DIV_TIMEOUT_EN
         to_q        <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (gnt_valid) begin
                  id_q <= gnt_id;
                  w_q  <= bus.req_w[32'(gnt_id)*W_W +: W_W];
                  d_q  <= bus.req_d[32'(gnt_id)*D_W +: D_W];
               end
            end
            S_WAIT: begin
               // div_done takes precedence over a watchdog expiry in the same cycle
               if (bus.div_done) begin
                  quo_q <= bus.div_quo;
                  rem_q <= bus.div_rem;
                  ov_q  <= bus.div_ov;
                  dbz_q <= bus.div_dbz;
`ifdef DIV_TIMEOUT_EN
                  to_q  <= 1'b0;
               end else if (to_exp) begin
                  quo_q <= '0;
                  rem_q <= '0;
                  ov_q  <= 1'b0;
                  dbz_q <= 1'b0;
                  to_q  <= 1'b1;
`endif
               end
            end
            S_RESP:  last_served <= id_q;
            default: ;
         endcase
      end
   end

   // Output decode; everything is forced low while rst is asserted.
   always_comb begin
      bus.busy       = 1'b0;
      bus.div_start  = 1'b0;
      bus.div_w      = '0;
      bus.div_d      = '0;
      bus.ack        = '0;
      bus.resp_valid = 1'b0;
      bus.resp_id    = '0;
      bus.resp_quo   = '0;
      bus.resp_rem   = '0;
      bus.resp_ov    = 1'b0;
      bus.resp_dbz   = 1'b0;
      bus.resp_to    = 1'b0;
      if (!rst) begin
         bus.busy = (state != S_IDLE);
         unique case (state)
            S_ISSUE: begin
               bus.div_start = 1'b1;
               bus.div_w     = w_q;
               bus.div_d     = d_q;
            end
            S_WAIT: begin
               bus.div_w = w_q;
               bus.div_d = d_q;
            end
            S_RESP: begin
               bus.ack        = N_REQ'(1) << id_q;
               bus.resp_valid = 1'b1;
               bus.resp_id    = id_q;
               bus.resp_quo   = quo_q;
               bus.resp_rem   = rem_q;
               bus.resp_ov    = ov_q;
               bus.resp_dbz   = dbz_q;
`ifdef DIV_TIMEOUT_EN
               bus.resp_to    = to_q;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: table of single transactions plus
// hand sequences for arbitration order, reset abort and watchdog cases.
module tb_div_arbiter;
   import div_arb_pkg::*;

   localparam int unsigned N = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_arbiter_if #(.N_REQ(N)) bus ();

   div_arbiter #(
      .N_REQ       (N),
      .TIMEOUT_CYC (63)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- divider stub ----------------
   int unsigned lat  = 3;
   bit          hang = 1'b0;
   logic        spur = 1'b0;
   logic        stub_done = 1'b0;
   logic [4:0]  s_quo = '0;
   logic [5:0]  s_rem = '0;
   logic        s_ov  = 1'b0;
   logic        s_dbz = 1'b0;
   int unsigned s_cnt = 0;

   assign bus.div_done = stub_done | spur;
   assign bus.div_quo  = s_quo;
   assign bus.div_rem  = s_rem;
   assign bus.div_ov   = s_ov;
   assign bus.div_dbz  = s_dbz;

   // done appears lat cycles after the cycle in which div_start is high
   always @(posedge clk) begin
      stub_done <= 1'b0;
      if (rst) begin
         s_cnt <= 0;
         s_quo <= '0;
         s_rem <= '0;
         s_ov  <= 1'b0;
         s_dbz <= 1'b0;
      end else if (bus.div_start) begin
         if (bus.div_d == 5'd0) begin
            s_quo <= 5'd31;
            s_rem <= 6'd0;
            s_ov  <= 1'b0;
            s_dbz <= 1'b1;
         end else begin
            s_quo <= 5'(bus.div_w / 10'(bus.div_d));
            s_rem <= 6'(bus.div_w % 10'(bus.div_d));
            s_ov  <= (bus.div_w / 10'(bus.div_d)) > 10'd31;
            s_dbz <= 1'b0;
         end
         if (hang)          s_cnt <= 0;
         else if (lat == 1) begin
            stub_done <= 1'b1;
            s_cnt     <= 0;
         end else           s_cnt <= lat - 1;
      end else if (s_cnt != 0) begin
         s_cnt <= s_cnt - 1;
         if (s_cnt == 1) stub_done <= 1'b1;
      end
   end

   int unsigned starts = 0;
   always @(negedge clk) if (bus.div_start === 1'b1) starts <= starts + 1;

   // ---------------- checking ----------------
   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_resp(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 300) begin
         @(negedge clk);
         n++;
         ok = (bus.resp_valid === 1'b1);
      end
   endtask

   typedef struct {
      int unsigned id;
      logic [9:0]  w;
      logic [4:0]  d;
      int unsigned lat;
      logic [4:0]  quo;
      logic [5:0]  rem;
      logic        ov;
      logic        dbz;
   } vec_t;

   vec_t vt[8];

   int          n, n2;
   bit          ok;
   int unsigned st0;
   int          stray;
   logic [4:0]  rr_quo[4];
   logic [5:0]  rr_rem[4];

   initial begin
      vt[0] = '{0, 10'd75,   5'd11, 3, 5'd6,  6'd9,  1'b0, 1'b0};
      vt[1] = '{1, 10'd1013, 5'd25, 1, 5'd8,  6'd13, 1'b1, 1'b0};
      vt[2] = '{3, 10'd100,  5'd0,  2, 5'd31, 6'd0,  1'b0, 1'b1};
      vt[3] = '{2, 10'd1023, 5'd31, 4, 5'd1,  6'd0,  1'b1, 1'b0};
      vt[4] = '{1, 10'd31,   5'd1,  1, 5'd31, 6'd0,  1'b0, 1'b0};
      vt[5] = '{0, 10'd0,    5'd5,  2, 5'd0,  6'd0,  1'b0, 1'b0};
      vt[6] = '{2, 10'd500,  5'd17, 3, 5'd29, 6'd7,  1'b0, 1'b0};
      vt[7] = '{3, 10'd30,   5'd31, 1, 5'd0,  6'd30, 1'b0, 1'b0};

      rr_quo = '{5'd7, 5'd14, 5'd21, 5'd28};
      rr_rem = '{6'd1, 6'd2,  6'd3,  6'd4};

      rst       = 1'b1;
      bus.req   = '0;
      bus.req_w = '0;
      bus.req_d = '0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy",       bus.busy,       0);
      check("rst_ack",        bus.ack,        0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_div_start",  bus.div_start,  0);
      rst = 1'b0;
      @(negedge clk);

      // table of single-requester transactions
      for (int i = 0; i < 8; i++) begin
         lat       = vt[i].lat;
         st0       = starts;
         bus.req_w = '0;
         bus.req_d = '0;
         bus.req_w[vt[i].id*10 +: 10] = vt[i].w;
         bus.req_d[vt[i].id*5  +: 5]  = vt[i].d;
         bus.req   = 4'b0001 << vt[i].id;
         wait_resp(n, ok);
         check($sformatf("v%0d_seen", i),    ok,            1);
         check($sformatf("v%0d_latency", i), n,             vt[i].lat + 2);
         check($sformatf("v%0d_id", i),      bus.resp_id,   vt[i].id);
         check($sformatf("v%0d_quo", i),     bus.resp_quo,  vt[i].quo);
         check($sformatf("v%0d_rem", i),     bus.resp_rem,  vt[i].rem);
         check($sformatf("v%0d_ov", i),      bus.resp_ov,   vt[i].ov);
         check($sformatf("v%0d_dbz", i),     bus.resp_dbz,  vt[i].dbz);
         check($sformatf("v%0d_to", i),      bus.resp_to,   0);
         check($sformatf("v%0d_ack", i),     bus.ack,       4'b0001 << vt[i].id);
         check($sformatf("v%0d_starts", i),  starts - st0,  1);
         bus.req = '0;
         @(negedge clk);
         check($sformatf("v%0d_ack_off", i), bus.ack,       0);
         check($sformatf("v%0d_idle", i),    bus.busy,      0);
      end

      // div_done outside WAIT is ignored: in IDLE and in ISSUE
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      check("spur_idle_busy", bus.busy,       0);
      check("spur_idle_resp", bus.resp_valid, 0);
      lat       = 4;
      bus.req_w = '0;
      bus.req_d = '0;
      bus.req_w[2*10 +: 10] = 10'd213;
      bus.req_d[2*5  +: 5]  = 5'd25;
      bus.req   = 4'b0100;
      @(negedge clk);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      check("spur_issue_resp", bus.resp_valid, 0);
      wait_resp(n, ok);
      check("spur_latency", n + 2,        lat + 2);
      check("spur_quo",     bus.resp_quo, 8);
      check("spur_rem",     bus.resp_rem, 13);
      bus.req = '0;
      @(negedge clk);

      // two simultaneous requesters: 0 then 2, one IDLE cycle between
      lat       = 2;
      bus.req_w = '0;
      bus.req_d = '0;
      bus.req_w[0*10 +: 10] = 10'd91;
      bus.req_d[0*5  +: 5]  = 5'd15;
      bus.req_w[2*10 +: 10] = 10'd213;
      bus.req_d[2*5  +: 5]  = 5'd25;
      bus.req   = 4'b0101;
      wait_resp(n, ok);
      check("pair_first_id",  bus.resp_id,  0);
      check("pair_first_quo", bus.resp_quo, 6);
      check("pair_first_rem", bus.resp_rem, 1);
      check("pair_first_lat", n,            lat + 2);
      bus.req[0] = 1'b0;
      wait_resp(n2, ok);
      check("pair_second_id",  bus.resp_id,  2);
      check("pair_second_quo", bus.resp_quo, 8);
      check("pair_second_rem", bus.resp_rem, 13);
      check("pair_second_gap", n2,           lat + 3);
      bus.req = '0;
      @(negedge clk);

      // reset in WAIT abandons the operation
      hang      = 1'b1;
      bus.req_w = '0;
      bus.req_d = '0;
      bus.req_w[1*10 +: 10] = 10'd300;
      bus.req_d[1*5  +: 5]  = 5'd7;
      bus.req   = 4'b0010;
      repeat (4) @(negedge clk);
      check("wait_busy",  bus.busy,      1);
      check("wait_div_w", bus.div_w,     300);
      check("wait_div_d", bus.div_d,     7);
      check("wait_start", bus.div_start, 0);
      rst = 1'b1;
      #1;
      check("rst_mid_busy_comb", bus.busy, 0);
      @(negedge clk);
      bus.req = '0;
      rst     = 1'b0;
      hang    = 1'b0;
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_ack",  bus.ack,  0);
      stray = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.ack !== '0 || bus.resp_valid !== 1'b0) stray++;
      end
      check("rst_mid_no_ack", stray, 0);

      // all four held: strict rotation 0,1,2,3,0,1,2,3 after reset
      lat       = 1;
      bus.req_w = '0;
      bus.req_d = '0;
      for (int r = 0; r < 4; r++) begin
         bus.req_w[r*10 +: 10] = 10'(50 * (r + 1));
         bus.req_d[r*5  +: 5]  = 5'd7;
      end
      bus.req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         wait_resp(n, ok);
         check($sformatf("rr%0d_seen", k), ok,           1);
         check($sformatf("rr%0d_id", k),   bus.resp_id,  k % 4);
         check($sformatf("rr%0d_ack", k),  bus.ack,      4'b0001 << (k % 4));
         check($sformatf("rr%0d_quo", k),  bus.resp_quo, rr_quo[k % 4]);
         check($sformatf("rr%0d_rem", k),  bus.resp_rem, rr_rem[k % 4]);
         @(negedge clk);
         check($sformatf("rr%0d_ack_1cyc", k), bus.ack, 0);
      end
      bus.req = '0;
      repeat (8) @(negedge clk);

`ifdef DIV_TIMEOUT_EN
      // divider never answers: watchdog response 64 cycles after WAIT entry
      hang      = 1'b1;
      bus.req_w = '0;
      bus.req_d = '0;
      bus.req_w[2*10 +: 10] = 10'd213;
      bus.req_d[2*5  +: 5]  = 5'd25;
      bus.req   = 4'b0100;
      wait_resp(n, ok);
      check("to_latency", n,             66);
      check("to_flag",    bus.resp_to,   1);
      check("to_id",      bus.resp_id,   2);
      check("to_quo",     bus.resp_quo,  0);
      check("to_rem",     bus.resp_rem,  0);
      check("to_ov",      bus.resp_ov,   0);
      check("to_dbz",     bus.resp_dbz,  0);
      check("to_ack",     bus.ack,       4'b0100);
      bus.req = '0;
      @(negedge clk);
      hang = 1'b0;

      // done in the expiry cycle wins
      lat = 64;
      bus.req_w[1*10 +: 10] = 10'd91;
      bus.req_d[1*5  +: 5]  = 5'd15;
      bus.req = 4'b0010;
      wait_resp(n, ok);
      check("race_latency", n,            66);
      check("race_to",      bus.resp_to,  0);
      check("race_quo",     bus.resp_quo, 6);
      check("race_rem",     bus.resp_rem, 1);
      bus.req = '0;
      @(negedge clk);

      // done one cycle too late: timeout, late done lands in RESP and is ignored
      lat = 65;
      bus.req = 4'b0010;
      wait_resp(n, ok);
      check("late_latency", n,            66);
      check("late_to",      bus.resp_to,  1);
      check("late_quo",     bus.resp_quo, 0);
      bus.req = '0;
      @(negedge clk);
      check("late_idle", bus.busy, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
